// File: rtl/hex_keypad_pkg.sv
// Shared types and helpers for the hex keypad scanner: FSM states, key map
// and row decoding.
package hex_keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED
  } state_t;

  // Indexed by {row, col}; '*' and '#' report as E and F.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] onehot);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (onehot[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/hex_keypad_entry_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones so idle
// pulled-up keypad rows read as "no key" straight out of reset.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner: column scan, strobed debounce of press and release,
// and a 4-digit shift register feeding the seven-segment display driver.
module hex_keypad_entry
  import hex_keypad_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE_N = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  row_i,
  input  logic        clr_i,
  output logic [3:0]  col_o,
  output logic [15:0] data_o,
  output logic [3:0]  key_code_o,
  output logic        key_valid_o,
  output logic        key_held_o
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_N + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_N - 1);

  logic [3:0]    rs;
  logic          strobe;
  logic          key_ok;
  logic [1:0]    key_row;

  state_t        state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [BW-1:0] deb_q, deb_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    row_q, row_d;
  logic [15:0]   data_q, data_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (row_i),
    .q_o   (rs)
  );

  assign strobe  = (dwell_q == DWELL_LAST);
  assign key_ok  = is_onehot(~rs);
  assign key_row = onehot_to_idx(~rs);

  always_comb begin
    state_d   = state_q;
    deb_d     = deb_q;
    col_idx_d = col_idx_q;
    row_d     = row_q;
    data_d    = data_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    held_d    = held_q;
    dwell_d   = strobe ? '0 : dwell_q + DW'(1);

    case (state_q)
      SCAN: begin
        if (strobe) begin
          if (key_ok) begin
            row_d   = key_row;
            deb_d   = BW'(1);
            state_d = DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (strobe) begin
          if (key_ok && (key_row == row_q)) begin
            if (deb_q == DEB_LAST) begin
              code_d  = KEY_MAP[{row_q, col_idx_q}];
              data_d  = {data_q[11:0], KEY_MAP[{row_q, col_idx_q}]};
              valid_d = 1'b1;
              held_d  = 1'b1;
              deb_d   = '0;
              state_d = PRESSED;
            end else begin
              deb_d = deb_q + BW'(1);
            end
          end else begin
            deb_d   = '0;
            state_d = SCAN;
          end
        end
      end
      PRESSED: begin
        // Any single-key sample, even a different key, restarts the release count.
        if (strobe) begin
          if (key_ok) begin
            deb_d = '0;
          end else if (deb_q == DEB_LAST) begin
            deb_d     = '0;
            held_d    = 1'b0;
            col_idx_d = col_idx_q + 2'd1;
            state_d   = SCAN;
          end else begin
            deb_d = deb_q + BW'(1);
          end
        end
      end
      default: begin
        deb_d   = '0;
        state_d = SCAN;
      end
    endcase

    if (clr_i) data_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= SCAN;
      dwell_q   <= '0;
      deb_q     <= '0;
      col_idx_q <= '0;
      row_q     <= '0;
      data_q    <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      deb_q     <= deb_d;
      col_idx_q <= col_idx_d;
      row_q     <= row_d;
      data_q    <= data_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
    end
  end

  assign col_o       = ~(4'b0001 << col_idx_q);
  assign data_o      = data_q;
  assign key_code_o  = code_q;
  assign key_valid_o = valid_q;
  assign key_held_o  = held_q;

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Bench for hex_keypad_entry: physical keypad model, strobe-level reference
// model compared every cycle, plus directed scenario checks.
module tb_hex_keypad_entry;

  localparam int SCAN_DIV   = 4;
  localparam int DEBOUNCE_N = 3;

  logic        clk_i;
  logic        rst_i;
  logic [3:0]  row_i;
  logic        clr_i;
  logic [3:0]  col_o;
  logic [15:0] data_o;
  logic [3:0]  key_code_o;
  logic        key_valid_o;
  logic        key_held_o;

  logic [15:0] pressed;
  int checks;
  int errors;
  int pulses;

  logic [3:0] kmap [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  hex_keypad_entry #(
    .SCAN_DIV   (SCAN_DIV),
    .DEBOUNCE_N (DEBOUNCE_N)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .row_i       (row_i),
    .clr_i       (clr_i),
    .col_o       (col_o),
    .data_o      (data_o),
    .key_code_o  (key_code_o),
    .key_valid_o (key_valid_o),
    .key_held_o  (key_held_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Switch matrix: a closed key pulls its row low while its column is driven.
  always_comb begin
    row_i = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the keypad behaviour stated as strobe-by-strobe rules.
  int         m_tick   = 0;
  int         m_col    = 0;
  int         m_cand   = -1;
  int         m_streak = 0;
  int         m_quiet  = 0;
  bit         m_held   = 0;
  bit         m_valid  = 0;
  logic [15:0] m_data  = '0;
  logic [3:0]  m_code  = '0;
  logic [3:0]  m_rs    = 4'hF;
  logic [3:0]  m_s1    = 4'hF;

  function automatic int single_low(input logic [3:0] v);
    int n, r;
    n = 0;
    r = -1;
    for (int i = 0; i < 4; i++) if (!v[i]) begin n++; r = i; end
    return (n == 1) ? r : -1;
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_tick = 0; m_col = 0; m_cand = -1; m_streak = 0; m_quiet = 0;
      m_held = 0; m_valid = 0; m_data = '0; m_code = '0;
      m_rs = 4'hF; m_s1 = 4'hF;
    end else begin
      int r;
      bit strobe;
      m_valid = 0;
      strobe = (m_tick == SCAN_DIV - 1);
      m_tick = strobe ? 0 : m_tick + 1;
      if (strobe) begin
        r = single_low(m_rs);
        if (m_held) begin
          m_quiet = (r >= 0) ? 0 : m_quiet + 1;
          if (m_quiet == DEBOUNCE_N) begin
            m_held = 0;
            m_col = (m_col + 1) % 4;
          end
        end else if (m_cand < 0) begin
          if (r >= 0) begin
            m_cand = r;
            m_streak = 1;
          end else begin
            m_col = (m_col + 1) % 4;
          end
        end else if (r == m_cand) begin
          m_streak++;
          if (m_streak == DEBOUNCE_N) begin
            m_code = kmap[m_cand][m_col];
            m_data = {m_data[11:0], m_code};
            m_valid = 1;
            m_held = 1;
            m_quiet = 0;
            m_cand = -1;
          end
        end else begin
          m_cand = -1;
        end
      end
      if (clr_i) m_data = '0;
      m_rs = m_s1;
      m_s1 = row_i;
    end
  end

  logic [3:0] m_col_vec;
  always_comb begin
    m_col_vec = 4'hF;
    m_col_vec[m_col] = 1'b0;
  end

  always @(negedge clk_i) begin
    check_eq("outputs", {6'd0, col_o, data_o, key_code_o, key_valid_o, key_held_o},
             {6'd0, m_col_vec, m_data, m_code, m_valid, m_held});
    if (key_valid_o) pulses++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic key_pos(input logic [3:0] code, output int r, output int c);
    r = 0;
    c = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (kmap[i][j] == code) begin r = i; c = j; end
  endtask

  task automatic wait_pulse(input int budget, output bit seen);
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_i);
      if (key_valid_o) seen = 1;
    end
  endtask

  task automatic wait_held_low(input int budget, output bit seen);
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_i);
      if (!key_held_o) seen = 1;
    end
  endtask

  task automatic press(input logic [3:0] code);
    int r, c;
    key_pos(code, r, c);
    pressed[r*4+c] = 1'b1;
  endtask

  task automatic release_all();
    bit seen;
    pressed = '0;
    wait_held_low(200, seen);
    check_eq("release_seen", {31'd0, seen}, 32'd1);
    wait_cycles(4);
  endtask

  task automatic type_key(input logic [3:0] code);
    bit seen;
    press(code);
    wait_pulse(300, seen);
    check_eq("press_seen", {31'd0, seen}, 32'd1);
    check_eq("press_code", {28'd0, key_code_o}, {28'd0, code});
    wait_cycles(10);
    release_all();
  endtask

  task automatic clear_data();
    @(negedge clk_i);
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
    check_eq("clear", {16'd0, data_o}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] seq_exp [5] = '{16'h0001, 16'h0012, 16'h0123, 16'h123A, 16'h23A0};
  logic [3:0]  seq_key [5] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h0};

  initial begin
    bit seen;
    int p0;
    checks  = 0;
    errors  = 0;
    pulses  = 0;
    pressed = '0;
    clr_i   = 1'b0;
    rst_i   = 1'b1;
    #1 rst_i = 1'b0;
    wait_cycles(3);
    rst_i = 1'b1;

    // Idle scan order and reset values
    for (int k = 1; k <= 20; k++) begin
      logic [3:0] exp_col;
      @(negedge clk_i);
      exp_col = 4'hF;
      exp_col[(k / 4) % 4] = 1'b0;
      check_eq("idle_col", {28'd0, col_o}, {28'd0, exp_col});
      check_eq("idle_out", {9'd0, data_o, key_code_o, key_valid_o, key_held_o}, 32'd0);
    end

    // Key 6 (row 1, column 2)
    p0 = pulses;
    press(4'h6);
    wait_pulse(300, seen);
    check_eq("k6_seen", {31'd0, seen}, 32'd1);
    check_eq("k6_code", {28'd0, key_code_o}, 32'h6);
    check_eq("k6_data", {16'd0, data_o}, 32'h0006);
    check_eq("k6_held", {31'd0, key_held_o}, 32'd1);
    wait_cycles(40);
    check_eq("k6_no_repeat", pulses - p0, 32'd1);
    release_all();

    // Digit shift sequence
    clear_data();
    for (int i = 0; i < 5; i++) begin
      type_key(seq_key[i]);
      check_eq("seq_data", {16'd0, data_o}, {16'd0, seq_exp[i]});
    end

    // Bounce: two matching strobes, one open, then steady
    p0 = pulses;
    press(4'h6);
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk_i);
      if (m_cand >= 0 && m_streak == DEBOUNCE_N - 1) seen = 1;
    end
    check_eq("bounce_reach", {31'd0, seen}, 32'd1);
    pressed = '0;
    wait_cycles(6);
    check_eq("bounce_no_pulse", pulses - p0, 32'd0);
    press(4'h6);
    wait_pulse(300, seen);
    check_eq("bounce_seen", {31'd0, seen}, 32'd1);
    wait_cycles(20);
    check_eq("bounce_one", pulses - p0, 32'd1);
    release_all();

    // Two rows low in one column: keys 1 and 4
    p0 = pulses;
    press(4'h1);
    press(4'h4);
    wait_cycles(100);
    check_eq("dual_no_pulse", pulses - p0, 32'd0);
    pressed = '0;
    wait_cycles(20);

    // Long hold of key 5
    p0 = pulses;
    press(4'h5);
    wait_cycles(100 * SCAN_DIV + 40);
    check_eq("hold_one", pulses - p0, 32'd1);
    release_all();

    // Clear coinciding with accept
    clear_data();
    type_key(4'h1);
    type_key(4'h2);
    type_key(4'h3);
    type_key(4'h4);
    check_eq("pre_clr_data", {16'd0, data_o}, 32'h1234);
    press(4'h5);
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk_i);
      if (m_cand >= 0 && m_streak == DEBOUNCE_N - 1 && m_tick == SCAN_DIV - 1) seen = 1;
    end
    check_eq("clr_reach", {31'd0, seen}, 32'd1);
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
    check_eq("clr_acc_data", {16'd0, data_o}, 32'd0);
    check_eq("clr_acc_valid", {31'd0, key_valid_o}, 32'd1);
    check_eq("clr_acc_code", {28'd0, key_code_o}, 32'h5);
    wait_cycles(5);
    release_all();

    // Reset in the middle of a debounce
    press(4'h9);
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk_i);
      if (m_cand >= 0) seen = 1;
    end
    check_eq("rst_reach", {31'd0, seen}, 32'd1);
    #1 rst_i = 1'b0;
    #1 check_eq("rst_values", {6'd0, col_o, data_o, key_code_o, key_valid_o, key_held_o},
                {6'd0, 4'b1110, 16'd0, 4'd0, 1'b0, 1'b0});
    wait_cycles(3);
    rst_i = 1'b1;
    p0 = pulses;
    wait_cycles(8);
    check_eq("rst_no_pulse", pulses - p0, 32'd0);
    wait_pulse(300, seen);
    check_eq("rst_fresh", {31'd0, seen}, 32'd1);
    check_eq("rst_fresh_code", {28'd0, key_code_o}, 32'h9);
    release_all();

    // Randomized presses, bounce, multi-key and clears against the model
    for (int it = 0; it < 40; it++) begin
      logic [15:0] m;
      int len;
      m = '0;
      m[$urandom_range(15, 0)] = 1'b1;
      if ($urandom_range(3, 0) == 0) m[$urandom_range(15, 0)] = 1'b1;
      len = $urandom_range(120, 10);
      for (int k = 0; k < len; k++) begin
        @(negedge clk_i);
        pressed = ($urandom_range(7, 0) == 0) ? 16'd0 : m;
        clr_i = ($urandom_range(31, 0) == 0);
      end
      @(negedge clk_i);
      pressed = '0;
      clr_i = 1'b0;
      wait_cycles($urandom_range(60, 0));
    end
    wait_cycles(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
